// File: rtl/object_reporter_if.sv
// Record stream from object_reporter to the overlay/output stage.
// valid/ready: a record transfers on a clock edge where out_valid && out_ready; the master holds out_* stable while out_valid && !out_ready.
interface object_reporter_if #(
  parameter int WORD_SIZE = 8,
  parameter int OBJ_WIDTH = 12,
  parameter int LOC_SIZE  = 10
);
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_id;
  logic [LOC_SIZE-1:0]  out_x;
  logic [LOC_SIZE-1:0]  out_y;
  logic [OBJ_WIDTH-1:0] out_area;

  modport master (
    output out_valid, out_id, out_x, out_y, out_area,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_id, out_x, out_y, out_area,
    output out_ready
  );
endinterface

// File: rtl/object_reporter.sv
// Sweeps finished labels through the labeler's second data-table read port and
// emits one centroid record per surviving object on a valid/ready stream.
module object_reporter #(
  parameter int WORD_SIZE = 8,
  parameter int OBJ_WIDTH = 12,
  parameter int LOC_SIZE  = 10,
  parameter int RD_LAT    = 1,
  parameter int MIN_AREA  = 1,
  parameter int MAX_OBJS  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic [WORD_SIZE-1:0] num_labels,
  output logic [WORD_SIZE-1:0] obj_id,
  input  logic [OBJ_WIDTH-1:0] obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  object_reporter_if.master    rec,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] obj_count,
  output logic                 overrun,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EMIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [WORD_SIZE-1:0] ID_ONE   = 1;
  localparam logic [1:0]           LAT_INIT = 2'(RD_LAT);
  localparam logic [OBJ_WIDTH-1:0] MIN_A    = OBJ_WIDTH'(MIN_AREA);
  localparam logic [WORD_SIZE:0]   MAX_C    = (WORD_SIZE + 1)'(MAX_OBJS);

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_last;
  logic [WORD_SIZE-1:0] r_obj_id;
  logic [1:0]           r_wait;
  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_id;
  logic [LOC_SIZE-1:0]  r_out_x;
  logic [LOC_SIZE-1:0]  r_out_y;
  logic [OBJ_WIDTH-1:0] r_out_area;
  logic [WORD_SIZE-1:0] r_obj_count;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overrun;

  state_t               w_next;
  logic [WORD_SIZE-1:0] w_id_next;
  logic [1:0]           w_wait_next;
  logic                 w_start;
  logic                 w_sample;
  logic                 w_hs;
  logic                 w_empty;
  logic                 w_qualify;
  logic                 w_at_last;
  logic [WORD_SIZE-1:0] w_last_in;

  // num_labels of 0 is treated like 1 (no objects) so `last` can never wrap.
  assign w_empty   = (num_labels <= ID_ONE);
  assign w_last_in = w_empty ? '0 : (num_labels - ID_ONE);
  assign w_qualify = (obj_area >= MIN_A) && ({1'b0, r_obj_count} < MAX_C);
  assign w_at_last = (r_obj_id == r_last);

  always_comb begin
    w_next      = r_state;
    w_id_next   = r_obj_id;
    w_wait_next = r_wait;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_id_next = '0;
        if (frame_done) begin
          w_start = 1'b1;
          if (w_empty) begin
            w_next = S_FINISH;
          end else begin
            w_next      = S_FETCH;
            w_id_next   = ID_ONE;
            w_wait_next = LAT_INIT;
          end
        end
      end
      S_FETCH: begin
        if (r_wait != 2'd0) begin
          w_wait_next = r_wait - 2'd1;
        end else begin
          // Final FETCH cycle: table data for r_obj_id is valid now.
          w_sample = 1'b1;
          if (w_qualify) begin
            w_next = S_EMIT;
          end else if (w_at_last) begin
            w_next = S_FINISH;
          end else begin
            w_id_next   = r_obj_id + ID_ONE;
            w_wait_next = LAT_INIT;
          end
        end
      end
      S_EMIT: begin
        if (rec.out_ready) begin
          w_hs = 1'b1;
          if (w_at_last) begin
            w_next = S_FINISH;
          end else begin
            w_next      = S_FETCH;
            w_id_next   = r_obj_id + ID_ONE;
            w_wait_next = LAT_INIT;
          end
        end
      end
      S_FINISH: begin
        w_next    = S_IDLE;
        w_id_next = '0;
      end
      default: begin
        w_next    = S_IDLE;
        w_id_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= '0;
      r_obj_id    <= '0;
      r_wait      <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_area  <= '0;
      r_obj_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_obj_id    <= w_id_next;
      r_wait      <= w_wait_next;
      r_out_valid <= (w_next == S_EMIT);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_FINISH);
      if (w_start) begin
        r_last      <= w_last_in;
        r_obj_count <= '0;
      end else if (w_hs) begin
        r_obj_count <= r_obj_count + ID_ONE;
      end
      if (w_sample) begin
        r_out_id   <= r_obj_id;
        r_out_x    <= obj_x;
        r_out_y    <= obj_y;
        r_out_area <= obj_area;
      end
      if (frame_done && r_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign obj_id        = r_obj_id;
  assign rec.out_valid = r_out_valid;
  assign rec.out_id    = r_out_id;
  assign rec.out_x     = r_out_x;
  assign rec.out_y     = r_out_y;
  assign rec.out_area  = r_out_area;
  assign busy          = r_busy;
  assign done          = r_done;
  assign obj_count     = r_obj_count;
  assign overrun       = r_overrun;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_object_reporter.sv
// Bench for object_reporter: two instances (RD_LAT=1/MIN_AREA=1/MAX_OBJS=64 and
// RD_LAT=0/MIN_AREA=4/MAX_OBJS=2) share one table model and one stimulus stream.
module tb_object_reporter;
  localparam int WS = 8;
  localparam int OW = 12;
  localparam int LS = 10;
  localparam int RECW = WS + 2 * LS + OW;
  localparam int A_LAT = 1, A_MIN = 1, A_MAX = 64;
  localparam int B_LAT = 0, B_MIN = 4, B_MAX = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  logic          frame_done = 1'b0;
  logic [WS-1:0] num_labels = '0;
  logic          out_ready = 1'b1;

  logic [OW-1:0] t_area [0:255];
  logic [LS-1:0] t_x    [0:255];
  logic [LS-1:0] t_y    [0:255];

  object_reporter_if #(.WORD_SIZE(WS), .OBJ_WIDTH(OW), .LOC_SIZE(LS)) a_if ();
  object_reporter_if #(.WORD_SIZE(WS), .OBJ_WIDTH(OW), .LOC_SIZE(LS)) b_if ();
  assign a_if.out_ready = out_ready;
  assign b_if.out_ready = out_ready;

  logic [WS-1:0] a_obj_id, b_obj_id, a_id_d, a_count, b_count;
  logic [OW-1:0] a_area, b_area;
  logic [LS-1:0] a_x, a_y, b_x, b_y;
  logic a_busy, a_done, a_ovr, b_busy, b_done, b_ovr;
  logic [1:0] a_state, b_state;

  // table read port models: one register stage for A, combinational for B
  always @(posedge clk) a_id_d <= reset ? '0 : a_obj_id;
  assign a_area = t_area[a_id_d];
  assign a_x    = t_x[a_id_d];
  assign a_y    = t_y[a_id_d];
  assign b_area = t_area[b_obj_id];
  assign b_x    = t_x[b_obj_id];
  assign b_y    = t_y[b_obj_id];

  object_reporter #(.WORD_SIZE(WS), .OBJ_WIDTH(OW), .LOC_SIZE(LS),
                    .RD_LAT(A_LAT), .MIN_AREA(A_MIN), .MAX_OBJS(A_MAX)) dut_a (
    .clk(clk), .reset(reset), .frame_done(frame_done), .num_labels(num_labels),
    .obj_id(a_obj_id), .obj_area(a_area), .obj_x(a_x), .obj_y(a_y), .rec(a_if),
    .busy(a_busy), .done(a_done), .obj_count(a_count), .overrun(a_ovr),
    .o_dbg_state(a_state)
  );

  object_reporter #(.WORD_SIZE(WS), .OBJ_WIDTH(OW), .LOC_SIZE(LS),
                    .RD_LAT(B_LAT), .MIN_AREA(B_MIN), .MAX_OBJS(B_MAX)) dut_b (
    .clk(clk), .reset(reset), .frame_done(frame_done), .num_labels(num_labels),
    .obj_id(b_obj_id), .obj_area(b_area), .obj_x(b_x), .obj_y(b_y), .rec(b_if),
    .busy(b_busy), .done(b_done), .obj_count(b_count), .overrun(b_ovr),
    .o_dbg_state(b_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [RECW-1:0] exp_a[$];
  logic [RECW-1:0] exp_b[$];
  int exp_cnt[2];
  int exp_done[2];
  int done_seen[2] = '{0, 0};
  bit stalled[2] = '{1'b0, 1'b0};
  logic [RECW-1:0] held[2];
  logic [WS-1:0] held_id[2];
  bit timing_chk = 1'b0;
  int start_cyc = 0;
  int m_last = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the list of records a frame must produce and the done cycle with ready held high.
  task automatic predict(input int inst, input int n);
    int lat, mina, maxo, cnt, cyc;
    logic [WS-1:0] idv;
    lat  = (inst == 0) ? A_LAT : B_LAT;
    mina = (inst == 0) ? A_MIN : B_MIN;
    maxo = (inst == 0) ? A_MAX : B_MAX;
    cnt = 0;
    cyc = 1;
    for (int id = 1; id < n; id++) begin
      cyc += lat + 1;
      if (int'(t_area[id]) >= mina && cnt < maxo) begin
        cnt++;
        cyc++;
        idv = id[WS-1:0];
        if (inst == 0) exp_a.push_back({idv, t_x[id], t_y[id], t_area[id]});
        else           exp_b.push_back({idv, t_x[id], t_y[id], t_area[id]});
      end
    end
    exp_cnt[inst]  = cnt;
    exp_done[inst] = cyc;
  endtask

  task automatic mon(input int inst, input logic v, input logic [WS-1:0] rid,
                     input logic [LS-1:0] rx, input logic [LS-1:0] ry,
                     input logic [OW-1:0] ra, input logic [WS-1:0] oid,
                     input logic bsy, input logic dn, input logic [WS-1:0] cnt);
    logic [RECW-1:0] got, e;
    int sz;
    string p;
    p = (inst == 0) ? "a" : "b";
    got = {rid, rx, ry, ra};
    if (reset) begin
      stalled[inst] = 1'b0;
      return;
    end
    sz = (inst == 0) ? exp_a.size() : exp_b.size();
    if (stalled[inst]) begin
      check({p, ".hold_valid"}, 64'(v), 64'd1);
      check({p, ".hold_rec"}, 64'(got), 64'(held[inst]));
      check({p, ".hold_obj_id"}, 64'(oid), 64'(held_id[inst]));
    end
    if (bsy) check({p, ".id_le_last"}, 64'(int'(oid) <= m_last), 64'd1);
    else     check({p, ".idle_obj_id"}, 64'(oid), 64'd0);
    if (v && out_ready) begin
      check({p, ".rec_expected"}, 64'(sz > 0), 64'd1);
      if (sz > 0) begin
        if (inst == 0) e = exp_a.pop_front();
        else           e = exp_b.pop_front();
        check({p, ".rec"}, 64'(got), 64'(e));
      end
    end
    stalled[inst] = v && !out_ready;
    held[inst]    = got;
    held_id[inst] = oid;
    if (dn) begin
      sz = (inst == 0) ? exp_a.size() : exp_b.size();
      check({p, ".obj_count"}, 64'(cnt), 64'(exp_cnt[inst]));
      check({p, ".recs_left"}, 64'(sz), 64'd0);
      if (timing_chk) check({p, ".done_cycle"}, 64'(cyc_now - start_cyc), 64'(exp_done[inst]));
      done_seen[inst] = done_seen[inst] + 1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_if.out_valid, a_if.out_id, a_if.out_x, a_if.out_y, a_if.out_area,
        a_obj_id, a_busy, a_done, a_count);
    mon(1, b_if.out_valid, b_if.out_id, b_if.out_x, b_if.out_y, b_if.out_area,
        b_obj_id, b_busy, b_done, b_count);
  end

  // driver tasks
  task automatic check_reset_state();
    check("a.rst_obj_id", 64'(a_obj_id), 64'd0);
    check("a.rst_valid", 64'(a_if.out_valid), 64'd0);
    check("a.rst_rec", 64'({a_if.out_id, a_if.out_x, a_if.out_y, a_if.out_area}), 64'd0);
    check("a.rst_busy", 64'(a_busy), 64'd0);
    check("a.rst_done", 64'(a_done), 64'd0);
    check("a.rst_count", 64'(a_count), 64'd0);
    check("a.rst_overrun", 64'(a_ovr), 64'd0);
    check("a.rst_state_idle", 64'(a_state), 64'd0);
    check("b.rst_obj_id", 64'(b_obj_id), 64'd0);
    check("b.rst_valid", 64'(b_if.out_valid), 64'd0);
    check("b.rst_rec", 64'({b_if.out_id, b_if.out_x, b_if.out_y, b_if.out_area}), 64'd0);
    check("b.rst_busy", 64'(b_busy), 64'd0);
    check("b.rst_done", 64'(b_done), 64'd0);
    check("b.rst_count", 64'(b_count), 64'd0);
    check("b.rst_overrun", 64'(b_ovr), 64'd0);
  endtask

  task automatic fill_random(input int n);
    logic [31:0] r32;
    for (int id = 1; id < n; id++) begin
      r32 = $urandom_range(1, 12);
      t_area[id] = ($urandom_range(0, 3) == 0) ? '0 : r32[OW-1:0];
      r32 = $urandom; t_x[id] = r32[LS-1:0];
      r32 = $urandom; t_y[id] = r32[LS-1:0];
    end
  endtask

  task automatic set_label(input int id, input int area);
    logic [31:0] r32;
    r32 = area;     t_area[id] = r32[OW-1:0];
    r32 = $urandom; t_x[id] = r32[LS-1:0];
    r32 = $urandom; t_y[id] = r32[LS-1:0];
  endtask

  // rdy_mode: 0 ready high, 1 random ready, 2 stall the first A record for 5 cycles
  task automatic run_frame(input int n, input bit timing, input int rdy_mode, input int ovr_at);
    int d0, d1, k, stall_left;
    logic [31:0] r32;
    predict(0, n);
    predict(1, n);
    timing_chk = timing;
    m_last = (n > 1) ? n - 1 : 0;
    d0 = done_seen[0];
    d1 = done_seen[1];
    @(posedge clk); #1;
    frame_done = 1'b1;
    num_labels = n[WS-1:0];
    out_ready  = 1'b1;
    start_cyc  = cyc_now;
    @(posedge clk); #1;
    frame_done = 1'b0;
    r32 = $urandom;
    num_labels = r32[WS-1:0];
    check("a.first_obj_id", 64'(a_obj_id), 64'(n > 1));
    check("b.first_obj_id", 64'(b_obj_id), 64'(n > 1));
    check("a.busy_start", 64'(a_busy), 64'd1);
    check("b.busy_start", 64'(b_busy), 64'd1);
    check("a.count_clr", 64'(a_count), 64'd0);
    k = 1;
    stall_left = 5;
    while ((done_seen[0] == d0 || done_seen[1] == d1) && k < 3000) begin
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (a_if.out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      frame_done = (k == ovr_at);
      if (k == ovr_at) begin
        r32 = $urandom;
        num_labels = r32[WS-1:0];
      end
      @(posedge clk); #1;
      k++;
    end
    frame_done = 1'b0;
    out_ready  = 1'b1;
    check("sweeps_ended", 64'((done_seen[0] - d0) + (done_seen[1] - d1)), 64'd2);
  endtask

  task automatic reset_mid_emit();
    int k;
    for (int id = 1; id < 6; id++) set_label(id, 5 + id);
    predict(0, 6);
    predict(1, 6);
    timing_chk = 1'b0;
    m_last = 5;
    @(posedge clk); #1;
    frame_done = 1'b1;
    num_labels = 8'd6;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    frame_done = 1'b0;
    k = 0;
    while (!a_if.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("a.reached_emit", 64'(a_if.out_valid), 64'd1);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    check_reset_state();
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    bit rnd;
    for (int i = 0; i < 256; i++) begin
      t_area[i] = '0;
      t_x[i] = '0;
      t_y[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();

    // basic sweep: areas {10, 0, 5}
    set_label(1, 10); set_label(2, 0); set_label(3, 5);
    run_frame(4, 1'b1, 0, 0);
    // empty frame
    run_frame(1, 1'b1, 0, 0);
    // backpressure on the first record
    for (int id = 1; id < 4; id++) set_label(id, 5 + id);
    run_frame(4, 1'b0, 2, 0);
    // minimum area and record cap: areas {3, 4, 9, 7}
    set_label(1, 3); set_label(2, 4); set_label(3, 9); set_label(4, 7);
    run_frame(5, 1'b1, 0, 0);
    // overrun: second frame_done while busy
    fill_random(10);
    set_label(9, 8);
    run_frame(10, 1'b1, 0, 2);
    check("a.overrun_set", 64'(a_ovr), 64'd1);
    check("b.overrun_set", 64'(b_ovr), 64'd1);
    fill_random(3);
    run_frame(3, 1'b1, 0, 0);
    check("a.overrun_sticky", 64'(a_ovr), 64'd1);
    check("b.overrun_sticky", 64'(b_ovr), 64'd1);
    // reset while a record is stalled, then a clean frame
    reset_mid_emit();
    for (int id = 1; id < 4; id++) set_label(id, 4 + id);
    run_frame(4, 1'b1, 0, 0);
    // randomized frames
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 24);
      rnd = ($urandom_range(0, 1) == 1);
      fill_random(n);
      run_frame(n, !rnd, rnd ? 1 : 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
